fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Read-side consumer for the 8-bit synchronous FIFO. It pops bytes from the FIFO one at a time and shifts each one out as an asynchronous serial frame: start bit, 8 data bits LSB first, optional parity bit, then stop bit. A fixed clock divider sets the bit period. The block sits directly downstream of the FIFO, drives its `rd_enb`, consumes `rd_data`, and feeds the chip-level TX pin.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range is 2 or more.
- `DATA_W`, default 8: data width; must match the FIFO width.
- `clk`  in  1: single system clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `fifo_rd_data`  in  DATA_W: FIFO read data, valid the cycle after the FIFO samples `rd_enb`.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rd_enb`  out  1: registered one-cycle pop strobe to the FIFO.
- `tx`  out  1: serial line; idles high.
- `busy`  out  1: high from pop issue until the stop bit ends.
- `frame_done`  out  1: one-cycle pulse after the stop bit completes.

## Operation
- Reset values: `tx`=1, `fifo_rd_enb`=0, `busy`=0, `frame_done`=0, state=IDLE, counters=0.
- **IDLE**
  - If `fifo_empty`=0, set `fifo_rd_enb`<=1 and `busy`<=1, then go to POP.
  - Otherwise stay in IDLE.
- **POP**: set `fifo_rd_enb`<=0 and go to LOAD. This is exactly one pop per frame.
- **LOAD**: shift register <= `fifo_rd_data`, `tx`<=0 (start bit), baud counter<=0, go to START.
- **START / DATA / PARITY / STOP**: each bit holds for CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1.
  - At terminal count the block advances to the next bit.
  - DATA shifts right and drives `tx`=shift[0]; the bit index counts 0..7.
- **STOP**: `tx`=1. At terminal count: `frame_done`<=1, `busy`<=0, go to IDLE.
- Rules:
  - `fifo_rd_enb` is never asserted while `fifo_empty`=1, so no underrun is ever caused.
  - `fifo_full`, `fifo_almost_*`, `fifo_overrun` and `fifo_underrun` are not inputs.
  - Data bits are transmitted LSB first.
  - Counter widths: baud counter is $clog2(CLKS_PER_BIT) bits; bit index is 3 bits. Neither counter wraps except by terminal-count reload.
  - FIFO becomes empty mid-frame: the current frame completes normally, then the block stays in IDLE.
  - FIFO becomes non-empty in the same cycle STOP completes: the block sees it in the next IDLE cycle.
  - Reset mid-frame: the frame is aborted and the byte is lost. `tx`=1 the edge after reset is sampled. No partial frame resumes.

## Timing
- Edge N: IDLE samples `fifo_empty`=0. `fifo_rd_enb` is high from N to N+1.
- Edge N+1: the FIFO pops.
- Edge N+2: LOAD captures the byte. `tx` falls at N+2.
- Frame length on `tx`:
  - 10×CLKS_PER_BIT cycles.
  - 11×CLKS_PER_BIT cycles with parity.
- `frame_done` is high for one cycle, starting at the edge that ends STOP.
- Back-to-back frames: IDLE, POP and LOAD give 3 cycles of `tx`=1 between the stop bit and the next start bit.
- Reset-to-first-pop: first IDLE evaluation is 1 cycle after `rst` deasserts.

## Configuration
- `FIFO_UART_TX_PARITY_EN`
  - **Defined**: a PARITY state follows DATA, driving even parity (`tx` = XOR of the 8 data bits) for CLKS_PER_BIT cycles. The frame is 11 bits.
  - **Undefined**: DATA goes directly to STOP, and no parity logic is compiled. The frame is 10 bits.

## Structure
- Package `fifo_uart_pkg`:
  - state encoding IDLE, POP, LOAD, START, DATA, PARITY, STOP;
  - `FRAME_DATA_BITS`=8;
  - `START_LEVEL`=0, `STOP_LEVEL`=1.
- One sub-module, `baud_tick_gen`:
  - parameter CLKS_PER_BIT;
  - inputs `clk`, `rst`, `clr`;
  - output `tick` at terminal count.
  - The FSM asserts `clr` in LOAD.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- **Reset**: hold `rst` 2 cycles with `fifo_empty`=1 -> `tx`=1, `busy`=0, `fifo_rd_enb`=0; no pop for 20 cycles.
- **Single byte A5**: FIFO holds 8'hA5 -> exactly one 1-cycle `fifo_rd_enb`.
  - `tx` sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - `frame_done` pulses once at cycle 2+40.
- **Three bytes 10, 11, 12 queued** -> three pops, three frames decoded as 10, 11, 12 in order.
  - 3-cycle `tx`-high gap between frames.
  - `fifo_underrun` never asserts.
- **Drain to empty**: 8 bytes (10..17) -> 8 frames, then `busy`=0 and no 9th pop while `fifo_empty`=1.
- **Reset mid-frame**: assert `rst` during the DATA bit 3 of byte 8'h3C -> `tx`=1 next edge and no `frame_done`. The next queued byte 8'h55 is transmitted complete.
- **Parity (macro defined)**:
  - Byte 8'h07 -> parity bit 1, frame 44 cycles.
  - Byte 8'hA5 -> parity bit 0.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM states and frame constants.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    localparam int unsigned FRAME_DATA_BITS = 8;
    localparam logic        START_LEVEL     = 1'b0;
    localparam logic        STOP_LEVEL      = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count with tick.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] TermCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == TermCnt)) begin
            cnt_d = '0;
        end
        tick = !clr && (cnt_q == TermCnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one byte at a time from the upstream FIFO and sends it as a UART frame on tx.
// Define FIFO_UART_TX_PARITY_EN to append an even parity bit after the data bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_enb,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [2:0] LastBit = 3'(FRAME_DATA_BITS - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              tx_q, tx_d;
    logic              rd_enb_q, rd_enb_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              baud_clr;
    logic              baud_tick;

`ifdef FIFO_UART_TX_PARITY_EN
    logic par_q, par_d;
`endif

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (baud_clr),
        .tick(baud_tick)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        tx_d         = tx_q;
        rd_enb_d     = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        baud_clr     = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d        = par_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    rd_enb_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = StPop;
                end
            end
            StPop: begin
                state_d = StLoad;
            end
            StLoad: begin
                shift_d  = fifo_rd_data;
                tx_d     = START_LEVEL;
                baud_clr = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
                par_d    = ^fifo_rd_data;
`endif
                state_d  = StStart;
            end
            StStart: begin
                if (baud_tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (baud_tick) begin
                    if (bit_idx_q == LastBit) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = StParity;
`else
                        tx_d    = STOP_LEVEL;
                        state_d = StStop;
`endif
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            StParity: begin
                if (baud_tick) begin
                    tx_d    = STOP_LEVEL;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (baud_tick) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Reset drops any frame in flight; the line returns to idle-high immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            tx_q         <= STOP_LEVEL;
            rd_enb_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            tx_q         <= tx_d;
            rd_enb_q     <= rd_enb_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign fifo_rd_enb = rd_enb_q;
    assign tx          = tx_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with a queue-based FIFO and a frame-timeline model.
module tb_fifo_uart_tx;

    localparam int ClkPerBit = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FrameBits = 11;
`else
    localparam int FrameBits = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_enb;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int failures = 0;

    // FIFO model state
    logic [7:0] fifo_q[$];
    logic [7:0] push_arr[0:255];
    int         push_wr = 0;
    int         push_rd = 0;
    int         pops = 0;
    int         underruns = 0;

    // Model inputs/outputs
    logic [7:0] bq[$];
    logic [3:0] exp_a[0:2047];  // {tx, rd_enb, frame_done, busy}

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLKS_PER_BIT(ClkPerBit),
        .DATA_W      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty  (fifo_empty),
        .fifo_rd_enb (fifo_rd_enb),
        .tx          (tx),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always @(posedge clk) begin
        if (fifo_rd_enb) begin
            if (fifo_q.size() == 0) begin
                underruns <= underruns + 1;
            end else begin
                fifo_rd_data <= fifo_q.pop_front();
                pops <= pops + 1;
            end
        end
        for (int i = push_rd; i < push_wr; i++) fifo_q.push_back(push_arr[i]);
        push_rd <= push_wr;
        fifo_empty <= (fifo_q.size() == 0);
    end

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (FrameBits == 11 && j == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic push_bytes();
        @(negedge clk);
        foreach (bq[i]) begin
            push_arr[push_wr] = bq[i];
            push_wr++;
        end
    endtask

    // Builds the expected per-cycle timeline for the bytes in bq, then compares every cycle.
    task automatic test_stream(input string name, input int p0, input int extra, input int ncyc,
                               output int first_done, output int n_done);
        int n, p, st, dn, idx;
        logic [3:0] got;
        n = (ncyc > 0) ? ncyc : p0 + bq.size() * (FrameBits * ClkPerBit + 3) + extra;
        for (int t = 0; t < n; t++) exp_a[t] = 4'b1000;
        p = p0;
        foreach (bq[k]) begin
            st = p + 2;
            dn = st + FrameBits * ClkPerBit;
            for (int t = p; t < dn && t < n; t++) exp_a[t][0] = 1'b1;
            if (p < n) exp_a[p][2] = 1'b1;
            for (int j = 0; j < FrameBits; j++) begin
                for (int c = 0; c < ClkPerBit; c++) begin
                    idx = st + j * ClkPerBit + c;
                    if (idx < n) exp_a[idx][3] = frame_bit(bq[k], j);
                end
            end
            if (dn < n) exp_a[dn][1] = 1'b1;
            p = dn + 1;
        end
        first_done = -1;
        n_done = 0;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            got = {tx, fifo_rd_enb, frame_done, busy};
            if (frame_done === 1'b1) begin
                if (first_done < 0) first_done = t;
                n_done++;
            end
            checks++;
            if (got !== exp_a[t]) begin
                failures++;
                $display("FAIL %s t=%0d tx/rd/done/busy got=%b expected=%b", name, t, got,
                         exp_a[t]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx, busy, fifo_rd_enb, frame_done} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_outputs got=%b expected=1000",
                     {tx, busy, fifo_rd_enb, frame_done});
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_rd_enb !== 1'b0 || tx !== 1'b1) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d rd_enb=%b tx=%b expected rd_enb=0 tx=1",
                         i, fifo_rd_enb, tx);
            end
        end
    endtask

    task automatic test_single_a5();
        int p0, fd, nd;
        p0 = pops;
        bq.delete();
        bq.push_back(8'hA5);
        push_bytes();
        test_stream("single_a5", 1, 6, 0, fd, nd);
        checks++;
        if (pops - p0 !== 1) begin
            failures++;
            $display("FAIL single_pops got=%0d expected=1", pops - p0);
        end
        checks++;
        if (fd !== 3 + FrameBits * ClkPerBit || nd !== 1) begin
            failures++;
            $display("FAIL single_done_time got t=%0d count=%0d expected t=%0d count=1", fd, nd,
                     3 + FrameBits * ClkPerBit);
        end
    endtask

    task automatic test_back_to_back();
        int p0, fd, nd;
        p0 = pops;
        bq.delete();
        bq.push_back(8'h10);
        bq.push_back(8'h11);
        bq.push_back(8'h12);
        push_bytes();
        test_stream("three_bytes", 1, 6, 0, fd, nd);
        checks++;
        if (pops - p0 !== 3 || nd !== 3) begin
            failures++;
            $display("FAIL three_pops got pops=%0d frames=%0d expected 3/3", pops - p0, nd);
        end
    endtask

    task automatic test_drain();
        int p0, fd, nd;
        p0 = pops;
        bq.delete();
        for (int i = 0; i < 8; i++) bq.push_back(8'(8'h10 + i));
        push_bytes();
        test_stream("drain", 1, 20, 0, fd, nd);
        checks++;
        if (pops - p0 !== 8 || busy !== 1'b0 || fifo_empty !== 1'b1) begin
            failures++;
            $display("FAIL drain_end got pops=%0d busy=%b empty=%b expected 8/0/1", pops - p0,
                     busy, fifo_empty);
        end
    endtask

    task automatic test_random();
        int p0, fd, nd, cnt;
        for (int r = 0; r < 3; r++) begin
            p0 = pops;
            bq.delete();
            cnt = $urandom_range(1, 3);
            for (int i = 0; i < cnt; i++) bq.push_back(8'($urandom_range(0, 255)));
            push_bytes();
            test_stream("random", 1, 6, 0, fd, nd);
            checks++;
            if (pops - p0 !== cnt || nd !== cnt) begin
                failures++;
                $display("FAIL random_pops got pops=%0d frames=%0d expected %0d", pops - p0, nd,
                         cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        int p0, fd, nd;
        p0 = pops;
        bq.delete();
        bq.push_back(8'h3C);
        bq.push_back(8'h55);
        push_bytes();
        // Stop at the first cycle of data bit 3.
        test_stream("mid_pre", 1, 0, 3 + 4 * ClkPerBit + 1, fd, nd);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx, busy, fifo_rd_enb, frame_done} !== 4'b1000) begin
            failures++;
            $display("FAIL mid_reset got tx/busy/rd/done=%b expected=1000",
                     {tx, busy, fifo_rd_enb, frame_done});
        end
        rst = 1'b0;
        bq.delete();
        bq.push_back(8'h55);
        test_stream("mid_after", 0, 6, 0, fd, nd);
        checks++;
        if (pops - p0 !== 2 || nd !== 1) begin
            failures++;
            $display("FAIL mid_frames got pops=%0d frames=%0d expected 2/1", pops - p0, nd);
        end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity();
        int fd, nd;
        bq.delete();
        bq.push_back(8'h07);
        push_bytes();
        test_stream("parity_07", 1, 6, 0, fd, nd);
        checks++;
        if (fd !== 3 + 44) begin
            failures++;
            $display("FAIL parity_len got done_t=%0d expected=%0d", fd, 3 + 44);
        end
        bq.delete();
        bq.push_back(8'hA5);
        push_bytes();
        test_stream("parity_a5", 1, 6, 0, fd, nd);
    endtask
`endif

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_drain();
        test_random();
        test_reset_mid();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (underruns !== 0) begin
            failures++;
            $display("FAIL underrun got=%0d expected=0", underruns);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
